// File: rtl/avm_rr_arbiter_pkg.sv
// Shared definitions for the two-requester Avalon-MM round-robin arbiter:
// FSM state encoding and the data pattern returned on a watchdog abort.
package avm_rr_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CMD    = 2'd1,
    ST_RDWAIT = 2'd2
  } arb_state_e;

  // Sliced down to DATA_W by the user; wide enough for any realistic bus.
  localparam logic [1023:0] TIMEOUT_DATA = {1024{1'b1}};

endpackage

// File: rtl/avm_rr_arbiter_grant.sv
// Combinational two-way round-robin pick: a lone request always wins,
// a tie goes to the requester that was not granted last.
module avm_rr_grant (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  // One-hot winner selection
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/avm_rr_arbiter.sv
// Two-port Avalon-MM round-robin arbiter, one transaction outstanding.
// Optional watchdog abort is built when AVM_ARB_TIMEOUT_EN is defined.
module avm_rr_arbiter
  import avm_rr_arbiter_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                q_clock,
  input  logic                q_reset,
  input  logic [ADDR_W-1:0]   s0_address,
  input  logic [DATA_W-1:0]   s0_writedata,
  input  logic [DATA_W/8-1:0] s0_byteenable,
  input  logic                s0_read,
  input  logic                s0_write,
  output logic                s0_waitrequest,
  output logic [DATA_W-1:0]   s0_readdata,
  output logic                s0_readdatavalid,
  input  logic [ADDR_W-1:0]   s1_address,
  input  logic [DATA_W-1:0]   s1_writedata,
  input  logic [DATA_W/8-1:0] s1_byteenable,
  input  logic                s1_read,
  input  logic                s1_write,
  output logic                s1_waitrequest,
  output logic [DATA_W-1:0]   s1_readdata,
  output logic                s1_readdatavalid,
  output logic [ADDR_W-1:0]   m_address,
  output logic [DATA_W-1:0]   m_writedata,
  output logic [DATA_W/8-1:0] m_byteenable,
  output logic                m_read,
  output logic                m_write,
  output logic                m_begintransfer,
  input  logic [DATA_W-1:0]   m_readdata,
  input  logic                m_readdatavalid,
  input  logic                m_waitrequest,
  output logic                err_timeout
);

  localparam int BE_W = DATA_W / 8;

  arb_state_e        state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic [ADDR_W-1:0] m_address_q, m_address_d;
  logic [DATA_W-1:0] m_writedata_q, m_writedata_d;
  logic [BE_W-1:0]   m_byteenable_q, m_byteenable_d;
  logic              m_read_q, m_read_d;
  logic              m_write_q, m_write_d;
  logic              m_begin_q, m_begin_d;
  logic [1:0]        req_s, grant_s;
  logic              accept_s, rd_done_s, timeout_s, abort_rd_s;
  logic [DATA_W-1:0] rdata_s;

  assign req_s = {s1_read | s1_write, s0_read | s0_write};

  avm_rr_grant u_grant (
    .req   (req_s),
    .last  (last_q),
    .grant (grant_s)
  );

  assign accept_s  = (state_q == ST_CMD) && (!m_waitrequest || timeout_s);
  assign rd_done_s = (state_q == ST_RDWAIT) && m_readdatavalid;

`ifdef AVM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             abort_rd_q, abort_rd_d;

  // A genuine completion in the same cycle takes precedence over the watchdog.
  assign timeout_s = (state_q != ST_IDLE) && (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) &&
                     !((state_q == ST_CMD) && !m_waitrequest) && !rd_done_s;

  // Busy-cycle counter and abort pulses
  always_comb begin
    cnt_d      = cnt_q;
    err_d      = timeout_s;
    abort_rd_d = timeout_s && ((state_q == ST_RDWAIT) || m_read_q);
    if (state_q == ST_IDLE) begin
      cnt_d = {CNT_W{1'b0}};
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Watchdog registers
  always_ff @(posedge q_clock or posedge q_reset) begin
    if (q_reset) begin
      cnt_q      <= {CNT_W{1'b0}};
      err_q      <= 1'b0;
      abort_rd_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      abort_rd_q <= abort_rd_d;
    end
  end

  assign err_timeout = err_q;
  assign abort_rd_s  = abort_rd_q;
`else
  assign timeout_s   = 1'b0;
  assign abort_rd_s  = 1'b0;
  assign err_timeout = 1'b0;
`endif

  // State and registered master command
  always_ff @(posedge q_clock or posedge q_reset) begin
    if (q_reset) begin
      state_q        <= ST_IDLE;
      owner_q        <= 1'b0;
      last_q         <= 1'b1;
      m_address_q    <= {ADDR_W{1'b0}};
      m_writedata_q  <= {DATA_W{1'b0}};
      m_byteenable_q <= {BE_W{1'b0}};
      m_read_q       <= 1'b0;
      m_write_q      <= 1'b0;
      m_begin_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      last_q         <= last_d;
      m_address_q    <= m_address_d;
      m_writedata_q  <= m_writedata_d;
      m_byteenable_q <= m_byteenable_d;
      m_read_q       <= m_read_d;
      m_write_q      <= m_write_d;
      m_begin_q      <= m_begin_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (|req_s) state_d = ST_CMD;
        else        state_d = ST_IDLE;
      end
      ST_CMD: begin
        if (timeout_s)          state_d = ST_IDLE;
        else if (!m_waitrequest) state_d = m_write_q ? ST_IDLE : ST_RDWAIT;
        else                    state_d = ST_CMD;
      end
      ST_RDWAIT: begin
        if (rd_done_s || timeout_s) state_d = ST_IDLE;
        else                        state_d = ST_RDWAIT;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Command capture at grant, strobe clear at acceptance
  always_comb begin
    owner_d        = owner_q;
    last_d         = last_q;
    m_address_d    = m_address_q;
    m_writedata_d  = m_writedata_q;
    m_byteenable_d = m_byteenable_q;
    m_read_d       = m_read_q;
    m_write_d      = m_write_q;
    m_begin_d      = 1'b0;
    if ((state_q == ST_IDLE) && (|req_s)) begin
      owner_d   = grant_s[1];
      last_d    = grant_s[1];
      m_begin_d = 1'b1;
      if (grant_s[0]) begin
        m_address_d    = s0_address;
        m_writedata_d  = s0_writedata;
        m_byteenable_d = s0_byteenable;
        m_read_d       = s0_read;
        m_write_d      = s0_write;
      end else begin
        m_address_d    = s1_address;
        m_writedata_d  = s1_writedata;
        m_byteenable_d = s1_byteenable;
        m_read_d       = s1_read;
        m_write_d      = s1_write;
      end
    end else if (accept_s) begin
      m_read_d  = 1'b0;
      m_write_d = 1'b0;
    end else begin
      m_read_d  = m_read_q;
      m_write_d = m_write_q;
    end
  end

  assign m_address       = m_address_q;
  assign m_writedata     = m_writedata_q;
  assign m_byteenable    = m_byteenable_q;
  assign m_read          = m_read_q;
  assign m_write         = m_write_q;
  assign m_begintransfer = m_begin_q;

  assign s0_waitrequest = req_s[0] && !(accept_s && !owner_q);
  assign s1_waitrequest = req_s[1] && !(accept_s && owner_q);

  // Read return goes to the owner only; an abort substitutes all-ones data.
  assign rdata_s          = abort_rd_s ? TIMEOUT_DATA[DATA_W-1:0] : m_readdata;
  assign s0_readdatavalid = (rd_done_s || abort_rd_s) && !owner_q;
  assign s1_readdatavalid = (rd_done_s || abort_rd_s) && owner_q;
  assign s0_readdata      = owner_q ? {DATA_W{1'b0}} : rdata_s;
  assign s1_readdata      = owner_q ? rdata_s : {DATA_W{1'b0}};

endmodule
